// File: rtl/perf_pkg.sv
// Shared types for the performance counter bank: controller states, run modes,
// and the readback select width helper.
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE = 2'd0,
    MODE_WIN1 = 2'd1,
    MODE_WINR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_lane.sv
// One event channel: live counter with wrap or saturate, shadow register
// loaded on snapshot, and a sticky overflow flag.
module perf_counter_lane #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr_live,
  input  logic             clr_ovf,
  input  logic             clr_all,
  input  logic             load,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] live;
  logic [WIDTH-1:0] bumped;
  logic             wrap;

  assign wrap = inc && (live == ALL_ONES);

  always_comb begin
    // NOTE: default assignment first, so no path leaves bumped unassigned and no latch is inferred.
    bumped = live;
    if (inc) begin
      bumped = wrap ? ((SATURATE != 0) ? ALL_ONES : '0) : live + 1'b1;
    end
  end

  // NOTE: shadow is reset like any other register so an idle channel reads back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else if (clr_all) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; shadow must see this cycle's event, so it takes bumped, not live.
      live <= clr_live ? '0 : bumped;
      if (load) shadow <= bumped;
      if (clr_ovf)   ovf <= 1'b0;
      else if (wrap) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter: free-run or windowed counting, atomic snapshot
// of all channels into shadows, registered readback mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 32,
  parameter int WIN_W    = 24,
  parameter int SATURATE = 0,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] event_i,
  input  logic [1:0]          mode,
  input  logic [WIN_W-1:0]    win_len,
  input  logic                start,
  input  logic                stop,
  input  logic                snap,
  input  logic                clear,
  output logic                busy,
  output logic                done,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] ovf
);

  localparam int               SPAN    = 1 << SEL_W;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_e           state;
  mode_e            run_mode;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_load;
  logic             running;
  logic             windowed;
  logic             term;
  logic             snapshot;
  logic             start_ok;
  logic             count_en;
  logic             live_clr;
  logic [WIDTH-1:0] shadow   [CHANNELS];
  logic [WIDTH-1:0] rd_table [SPAN];

  assign running  = (state == RUN);
  assign windowed = (run_mode == MODE_WIN1) || (run_mode == MODE_WINR);
  assign term     = running && windowed && (win_cnt == WIN_ONE);
  assign count_en = running && !clear;
  // stop, terminal count and snap all capture the same data; clear suppresses all.
  assign snapshot = count_en && (stop || term || (snap && !windowed));
  assign start_ok = !running && !clear && start;
  assign live_clr = start_ok || (count_en && !stop && term && (run_mode == MODE_WINR));
  assign win_load = (win_len == '0) ? WIN_ONE : win_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      run_mode <= MODE_FREE;
      win_cnt  <= '0;
    end else begin
      done <= snapshot;
      if (clear) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              busy     <= 1'b1;
              run_mode <= (mode == MODE_RSVD) ? MODE_FREE : mode_e'(mode);
              win_cnt  <= win_load;
            end
          end
          RUN: begin
            if (stop || (term && (run_mode == MODE_WIN1))) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (term) begin
              win_cnt <= win_load;
            end else if (windowed) begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    perf_counter_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (count_en && event_i[g]),
      .clr_live (live_clr),
      .clr_ovf  (start_ok),
      .clr_all  (clear),
      .load     (snapshot),
      .shadow   (shadow[g]),
      .ovf      (ovf[g])
    );
  end

  // Select codes beyond the last channel map to constant zero entries.
  for (genvar g = 0; g < SPAN; g++) begin : g_rd
    if (g < CHANNELS) begin : g_ch
      assign rd_table[g] = shadow[g];
    end else begin : g_pad
      assign rd_table[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_table[rd_sel];
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized bench for perf_counter_bank: a 32-bit bank plus two 8-bit banks
// (wrap and saturate) share stimulus and are checked against per-channel tallies.
module tb_perf_counter_bank;

  localparam int CH   = 8;
  localparam int CH_S = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   ev;
  logic [1:0]      mode;
  logic [23:0]     win_len;
  logic            start, stop, snap, clear;
  logic [2:0]      rd_sel;

  logic            busy_a, done_a;
  logic [31:0]     rd_a;
  logic [CH-1:0]   ovf_a;
  logic            busy_w, done_w;
  logic [7:0]      rd_w;
  logic [CH_S-1:0] ovf_w;
  logic            busy_s, done_s;
  logic [7:0]      rd_s;
  logic [CH_S-1:0] ovf_s;

  int n_pass  = 0;
  int n_total = 0;
  int tally      [CH];  // events counted since live counters were last cleared
  int total      [CH];  // events counted since the last start or clear
  int snap_tally [CH];  // tally captured at the most recent snapshot

  always #5 clk = ~clk;

  perf_counter_bank #(.CHANNELS(CH), .WIDTH(32), .WIN_W(24), .SATURATE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .event_i(ev), .mode(mode), .win_len(win_len),
    .start(start), .stop(stop), .snap(snap), .clear(clear), .busy(busy_a),
    .done(done_a), .rd_sel(rd_sel), .rd_data(rd_a), .ovf(ovf_a)
  );

  perf_counter_bank #(.CHANNELS(CH_S), .WIDTH(8), .WIN_W(24), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .event_i(ev[CH_S-1:0]), .mode(mode), .win_len(win_len),
    .start(start), .stop(stop), .snap(snap), .clear(clear), .busy(busy_w),
    .done(done_w), .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w)
  );

  perf_counter_bank #(.CHANNELS(CH_S), .WIDTH(8), .WIN_W(24), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .event_i(ev[CH_S-1:0]), .mode(mode), .win_len(win_len),
    .start(start), .stop(stop), .snap(snap), .clear(clear), .busy(busy_s),
    .done(done_s), .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_model(input bit all);
    for (int i = 0; i < CH; i++) begin
      tally[i] = 0;
      if (all) total[i] = 0;
    end
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < CH; i++) snap_tally[i] = tally[i];
  endtask

  // One cycle in which the bank is counting: events land in the tallies.
  task automatic run_cycle(input logic [CH-1:0] e);
    ev = e;
    tick();
    ev = '0;
    for (int i = 0; i < CH; i++) begin
      if (e[i]) begin
        tally[i]++;
        total[i]++;
      end
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [23:0] wl);
    mode    = m;
    win_len = wl;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_shadows(input string tag);
    logic [7:0]      ew, es;
    logic [CH_S-1:0] eo;
    for (int c = 0; c < CH; c++) begin
      rd_sel = 3'(c);
      tick();
      n_total++;
      if (rd_a !== 32'(snap_tally[c]))
        $display("FAIL %s shadow32[%0d]: got %0d expected %0d", tag, c, rd_a, snap_tally[c]);
      else n_pass++;
      if (c < CH_S) begin
        ew = 8'(snap_tally[c] % 256);
        es = (snap_tally[c] > 255) ? 8'd255 : 8'(snap_tally[c]);
        n_total++;
        if (rd_w !== ew) $display("FAIL %s wrap8[%0d]: got %0d expected %0d", tag, c, rd_w, ew);
        else n_pass++;
        n_total++;
        if (rd_s !== es) $display("FAIL %s sat8[%0d]: got %0d expected %0d", tag, c, rd_s, es);
        else n_pass++;
      end
    end
    for (int c = 0; c < CH_S; c++) eo[c] = (total[c] > 255);
    n_total++;
    if (ovf_a !== '0 || ovf_w !== eo || ovf_s !== eo)
      $display("FAIL %s ovf: got %h/%h/%h expected 00/%h/%h", tag, ovf_a, ovf_w, ovf_s, eo, eo);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({busy_a, done_a, busy_w, done_w, busy_s, done_s} !== 6'b0 || ovf_a !== '0 || ovf_w !== '0)
      $display("FAIL reset_flags: got busy=%b done=%b ovf=%h expected all 0", busy_a, done_a, ovf_a);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    check_shadows("reset");
  endtask

  task automatic test_single_window();
    logic [CH-1:0] e;
    clear_model(1);
    start_run(2'd1, 24'd10);
    for (int k = 0; k < 10; k++) begin
      e    = 8'($urandom);
      e[0] = 1'b1;
      e[1] = (k % 2 == 1);
      run_cycle(e);
      n_total++;
      if (done_a !== (k == 9) || busy_a !== (k != 9))
        $display("FAIL win1_cycle%0d: got done=%b busy=%b expected done=%b busy=%b",
                 k, done_a, busy_a, (k == 9), (k != 9));
      else n_pass++;
    end
    take_snapshot();
    tick();
    n_total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL win1_after: got done=%b busy=%b expected 0 0", done_a, busy_a);
    else n_pass++;
    check_shadows("win1");
  endtask

  task automatic test_repeat_window();
    logic [CH-1:0] e;
    int            prev;
    prev   = snap_tally[0];
    rd_sel = 3'd0;
    clear_model(1);
    start_run(2'd2, 24'd4);
    for (int w = 0; w < 3; w++) begin
      clear_model(0);
      for (int k = 0; k < 4; k++) begin
        e    = 8'($urandom);
        e[0] = 1'b1;
        run_cycle(e);
        n_total++;
        if (done_a !== (k == 3) || busy_a !== 1'b1)
          $display("FAIL winr_w%0d_k%0d: got done=%b busy=%b expected done=%b busy=1",
                   w, k, done_a, busy_a, (k == 3));
        else n_pass++;
        n_total++;
        if (rd_a !== 32'((w == 0) ? prev : 4))
          $display("FAIL winr_read_w%0d_k%0d: got %0d expected %0d", w, k, rd_a, (w == 0) ? prev : 4);
        else n_pass++;
      end
    end
    clear_model(0);
    run_cycle(8'($urandom));
    run_cycle(8'($urandom));
    stop = 1'b1;
    run_cycle(8'($urandom));
    stop = 1'b0;
    n_total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL winr_stop: got done=%b busy=%b expected 1 0", done_a, busy_a);
    else n_pass++;
    take_snapshot();
    check_shadows("winr");
  endtask

  task automatic test_overflow();
    logic [CH-1:0] e;
    clear_model(1);
    start_run(2'd0, 24'd1);
    for (int i = 0; i < 300; i++) begin
      e    = 8'($urandom);
      e[0] = 1'b1;
      stop = (i == 299);
      run_cycle(e);
      stop = 1'b0;
    end
    n_total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL ovf_stop: got done=%b busy=%b expected 1 0", done_a, busy_a);
    else n_pass++;
    take_snapshot();
    check_shadows("overflow");
    rd_sel = 3'd0;
    tick();
    n_total++;
    if (rd_w !== 8'd44 || rd_s !== 8'd255 || ovf_w[0] !== 1'b1 || ovf_s[0] !== 1'b1)
      $display("FAIL ovf_ch0: got wrap=%0d sat=%0d ovf=%b%b expected 44 255 11",
               rd_w, rd_s, ovf_w[0], ovf_s[0]);
    else n_pass++;
  endtask

  task automatic test_snap();
    logic [CH-1:0] e;
    int            dones;
    int            guard;
    bit            stopped;
    bit            just_snapped;
    dones        = 0;
    guard        = 0;
    stopped      = 1'b0;
    just_snapped = 1'b0;
    rd_sel       = 3'd0;
    clear_model(1);
    start_run(2'd0, 24'd1);
    n_total++;
    if (ovf_w !== '0 || ovf_s !== '0)
      $display("FAIL start_clears_ovf: got %h/%h expected 00/00", ovf_w, ovf_s);
    else n_pass++;
    while (!stopped && guard < 200) begin
      e = 8'($urandom);
      if (e[0] && tally[0] == 6) snap = 1'b1;
      if (e[0] && tally[0] == 11) stop = 1'b1;
      run_cycle(e);
      if (done_a === 1'b1) dones++;
      if (just_snapped) begin
        n_total++;
        if (rd_a !== 32'd7 || busy_a !== 1'b1)
          $display("FAIL snap_read: got %0d busy=%b expected 7 busy=1", rd_a, busy_a);
        else n_pass++;
      end
      just_snapped = snap;
      if (stop) stopped = 1'b1;
      snap  = 1'b0;
      stop  = 1'b0;
      guard++;
    end
    n_total++;
    if (!stopped || dones != 2)
      $display("FAIL snap_dones: got %0d pulses stopped=%b expected 2 stopped=1", dones, stopped);
    else n_pass++;
    take_snapshot();
    check_shadows("snap_stop");
  endtask

  task automatic test_edge_cases();
    logic [CH-1:0] e;
    mode    = 2'd1;
    win_len = 24'd3;
    clear   = 1'b1;
    start   = 1'b1;
    tick();
    clear   = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (busy_a !== 1'b0 || done_a !== 1'b0)
        $display("FAIL clear_start_k%0d: got busy=%b done=%b expected 0 0", k, busy_a, done_a);
      else n_pass++;
    end
    clear_model(1);
    take_snapshot();
    check_shadows("clear");

    stop = 1'b1;
    tick();
    stop = 1'b0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    n_total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL idle_stop_snap: got done=%b busy=%b expected 0 0", done_a, busy_a);
    else n_pass++;

    clear_model(1);
    start_run(2'd1, 24'd5);
    for (int k = 0; k < 5; k++) begin
      e = 8'($urandom);
      if (k == 1) begin
        start   = 1'b1;
        win_len = 24'd20;
      end
      snap = (k == 2);
      run_cycle(e);
      start = 1'b0;
      snap  = 1'b0;
      n_total++;
      if (done_a !== (k == 4))
        $display("FAIL busy_start_k%0d: got done=%b expected %b", k, done_a, (k == 4));
      else n_pass++;
    end
    take_snapshot();
    check_shadows("busy_start");

    for (int wl = 0; wl < 2; wl++) begin
      clear_model(1);
      start_run(2'd1, 24'(wl));
      run_cycle(8'($urandom) | 8'h01);
      n_total++;
      if (done_a !== 1'b1 || busy_a !== 1'b0)
        $display("FAIL win_len%0d: got done=%b busy=%b expected 1 0", wl, done_a, busy_a);
      else n_pass++;
      take_snapshot();
      check_shadows("one_cycle_window");
    end
  endtask

  task automatic test_reset_mid_window();
    clear_model(1);
    start_run(2'd0, 24'd1);
    run_cycle(8'hFF);
    run_cycle(8'hFF);
    run_cycle(8'hFF);
    stop = 1'b1;
    run_cycle(8'hFF);
    stop = 1'b0;
    take_snapshot();
    check_shadows("pre_reset");
    for (int s = CH_S; s < CH; s++) begin
      rd_sel = 3'(s);
      tick();
      n_total++;
      if (rd_w !== 8'd0 || rd_s !== 8'd0)
        $display("FAIL sel_range%0d: got %0d/%0d expected 0/0", s, rd_w, rd_s);
      else n_pass++;
    end

    rd_sel = 3'd0;
    start_run(2'd1, 24'd10);
    for (int k = 0; k < 4; k++) begin
      ev = 8'hFF;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy_a, done_a, busy_w, done_s} !== 4'b0 || rd_a !== '0 || rd_w !== '0 || ovf_w !== '0)
      $display("FAIL reset_async: got busy=%b done=%b rd=%0d expected 0 0 0", busy_a, done_a, rd_a);
    else n_pass++;
    ev = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_total++;
      if (done_a !== 1'b0 || busy_a !== 1'b0)
        $display("FAIL reset_after_k%0d: got done=%b busy=%b expected 0 0", k, done_a, busy_a);
      else n_pass++;
    end
    clear_model(1);
    take_snapshot();
    check_shadows("post_reset");
  endtask

  task automatic test_random_windows();
    logic [CH-1:0] e;
    int            m;
    int            n;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, 2);
      clear_model(1);
      if (m == 1) begin
        win_len = 24'($urandom_range(0, 7));
        n       = (win_len == 24'd0) ? 1 : int'(win_len);
        start_run(2'd1, win_len);
      end else begin
        n = $urandom_range(2, 9);
        start_run((m == 2) ? 2'd3 : 2'd0, 24'd1);
      end
      for (int k = 0; k < n; k++) begin
        e    = 8'($urandom);
        stop = (m != 1) && (k == n - 1);
        run_cycle(e);
        stop = 1'b0;
        n_total++;
        if (done_a !== (k == n - 1))
          $display("FAIL rand%0d_k%0d: got done=%b expected %b", it, k, done_a, (k == n - 1));
        else n_pass++;
      end
      n_total++;
      if (busy_a !== 1'b0) $display("FAIL rand%0d_busy: got %b expected 0", it, busy_a);
      else n_pass++;
      take_snapshot();
      check_shadows("random");
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ev      = '0;
    mode    = 2'd0;
    win_len = 24'd0;
    start   = 1'b0;
    stop    = 1'b0;
    snap    = 1'b0;
    clear   = 1'b0;
    rd_sel  = 3'd0;
    clear_model(1);
    take_snapshot();
    test_reset();
    test_single_window();
    test_repeat_window();
    test_overflow();
    test_snap();
    test_edge_cases();
    test_reset_mid_window();
    test_random_windows();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
